target_generator: RTL

Upstream feeder for the score counter. Places the snake's target at a pseudo-random in-range grid cell and compares each new snake head position against it. On a hit it emits a one-cycle TARGET_REACHED pulse, which drives the score counter's increment, then relocates the target. Target coordinates also go to the VGA/display stage.

---
 rtl/target_generator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/target_generator.sv
// Target placement for the snake game: free-running LFSRs pick an in-range cell,
// and a registered one-cycle pulse fires when a strobed head position lands on it.
module target_generator #(
  parameter int unsigned          X_WIDTH   = 8,
  parameter int unsigned          Y_WIDTH   = 7,
  parameter int unsigned          X_MAX     = 159,
  parameter int unsigned          Y_MAX     = 119,
  parameter logic [X_WIDTH-1:0]   X_SEED    = 8'hA5,
  parameter logic [Y_WIDTH-1:0]   Y_SEED    = 7'h3C,
  parameter int unsigned          MAX_RETRY = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               GAME_ACTIVE,
  input  logic               HEAD_VALID,
  input  logic [X_WIDTH-1:0] HEAD_X,
  input  logic [Y_WIDTH-1:0] HEAD_Y,
  output logic [X_WIDTH-1:0] TARGET_X,
  output logic [Y_WIDTH-1:0] TARGET_Y,
  output logic               TARGET_VALID,
  output logic               TARGET_REACHED
);

  // Maximal-length Fibonacci tap masks; bit n-1 set for polynomial term x^n.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      2:       lfsr_taps = 32'h0000_0003;
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0829;
      13:      lfsr_taps = 32'h0000_100D;
      14:      lfsr_taps = 32'h0000_2015;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      default: lfsr_taps = 32'h0000_0003;
    endcase
  endfunction

  localparam logic [X_WIDTH-1:0] X_TAPS  = X_WIDTH'(lfsr_taps(X_WIDTH));
  localparam logic [Y_WIDTH-1:0] Y_TAPS  = Y_WIDTH'(lfsr_taps(Y_WIDTH));
  localparam int unsigned        RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [X_WIDTH-1:0] X_LIMIT = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] Y_LIMIT = Y_WIDTH'(Y_MAX);
  localparam logic [X_WIDTH-1:0] X_FALLBACK = X_WIDTH'(X_MAX >> 1);
  localparam logic [Y_WIDTH-1:0] Y_FALLBACK = Y_WIDTH'(Y_MAX >> 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    ARMED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [X_WIDTH-1:0]   lfsr_x_q, lfsr_x_d;
  logic [Y_WIDTH-1:0]   lfsr_y_q, lfsr_y_d;
  logic [X_WIDTH-1:0]   target_x_q, target_x_d;
  logic [Y_WIDTH-1:0]   target_y_q, target_y_d;
  logic                 valid_q, valid_d;
  logic                 reached_q, reached_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 sample_ok;
  logic                 head_hit;

  // Next-state, placement and hit detection.
  always_comb begin
    state_d    = state_q;
    target_x_d = target_x_q;
    target_y_d = target_y_q;
    retry_d    = retry_q;
    valid_d    = 1'b0;
    reached_d  = 1'b0;
    lfsr_x_d   = {lfsr_x_q[X_WIDTH-2:0], ^(lfsr_x_q & X_TAPS)};
    lfsr_y_d   = {lfsr_y_q[Y_WIDTH-2:0], ^(lfsr_y_q & Y_TAPS)};

    sample_ok = (lfsr_x_q <= X_LIMIT) && (lfsr_y_q <= Y_LIMIT) &&
                !((lfsr_x_q == HEAD_X) && (lfsr_y_q == HEAD_Y));
    head_hit  = HEAD_VALID && (HEAD_X == target_x_q) && (HEAD_Y == target_y_q);

    case (state_q)
      IDLE: begin
        if (GAME_ACTIVE) begin
          state_d = PLACE;
          retry_d = '0;
        end
      end
      PLACE: begin
        if (!GAME_ACTIVE) begin
          state_d = IDLE;
        end else if (sample_ok) begin
          target_x_d = lfsr_x_q;
          target_y_d = lfsr_y_q;
          retry_d    = '0;
          state_d    = ARMED;
          valid_d    = 1'b1;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + RETRY_W'(1);
        end else begin
          // Out of retries: centre of the field, even if the head sits there.
          target_x_d = X_FALLBACK;
          target_y_d = Y_FALLBACK;
          retry_d    = '0;
          state_d    = ARMED;
          valid_d    = 1'b1;
        end
      end
      ARMED: begin
        if (head_hit) begin
          reached_d = 1'b1;
          retry_d   = '0;
          state_d   = GAME_ACTIVE ? PLACE : IDLE;
        end else if (!GAME_ACTIVE) begin
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      lfsr_x_q   <= X_SEED;
      lfsr_y_q   <= Y_SEED;
      target_x_q <= '0;
      target_y_q <= '0;
      valid_q    <= 1'b0;
      reached_q  <= 1'b0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_x_q   <= lfsr_x_d;
      lfsr_y_q   <= lfsr_y_d;
      target_x_q <= target_x_d;
      target_y_q <= target_y_d;
      valid_q    <= valid_d;
      reached_q  <= reached_d;
      retry_q    <= retry_d;
    end
  end

  assign TARGET_X       = target_x_q;
  assign TARGET_Y       = target_y_q;
  assign TARGET_VALID   = valid_q;
  assign TARGET_REACHED = reached_q;

endmodule
